piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out stage that feeds the din input of the Moore 1x01 overlapping pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding register lets back-to-back words stream with no idle gap. Frame markers and a valid flag accompany the serial bit so downstream logic can qualify it.

Parameters:
WIDTH, 4, word length in bits; WIDTH >= 2.
LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB shifted out first.
IDLE_BIT, 0, value driven on dout when no word is shifting.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
data_in  input  WIDTH  parallel word to serialize
load_valid  input  1  data_in is valid
load_ready  output  1  block can take a word this cycle
flush  input  1  synchronous abort; discards shifter and hold contents
dout  output  1  serial bit; connects to detector din
dout_valid  output  1  dout carries a real data bit
frame_start  output  1  dout is bit 0 of a word
frame_end  output  1  dout is bit WIDTH-1 of a word
busy  output  1  shifter active or hold register full

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, shift register = 0, bit counter = 0, hold empty. Outputs: dout=IDLE_BIT, dout_valid=0, frame_start=0, frame_end=0, busy=0, load_ready=0.
- After reset release, load_ready = !hold_full && !flush (combinational).
- Accept: a word is taken on a rising edge where load_valid && load_ready.
- States:
  - IDLE: on accept, load the word into the shifter, clear the counter, go to SHIFT.
  - SHIFT: dout_valid=1; the counter advances each edge; at counter = WIDTH-1 (the last bit) the next state follows the last-bit priority below.
- Last-bit priority (edge ending the last bit):
  1. If hold is full, hold moves into the shifter and hold empties.
  2. Else, if a word is accepted on that edge, it goes straight into the shifter.
  3. Else, go to IDLE.
- Mid-word accept (SHIFT, not the last bit): the word goes into hold and hold_full=1. The case "last bit with hold full" cannot also accept a word, because load_ready=0.
- Latency: accept edge N; the first bit appears on dout in cycle N+1. Back-to-back words give exactly WIDTH consecutive valid cycles per word with no gap.
- Bit order: MSB first shifts left and drives dout from shifter[WIDTH-1]; LSB first shifts right and drives dout from shifter[0].
- frame_start=1 when the counter is 0 and in SHIFT; frame_end=1 when the counter is WIDTH-1 and in SHIFT.
- flush=1 at an edge: go to IDLE, empty hold, counter=0, dout=IDLE_BIT next cycle. flush overrides any accept (load_ready=0 while flush=1).
- IDLE: dout=IDLE_BIT, dout_valid=0.
- busy = (state==SHIFT) || hold_full.
- Reset asserted mid-word: all state clears immediately; the partial word is lost.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1 and wraps to 0 on reload.

Test Plan:
- Reset then single word: WIDTH=4, MSB first, data_in=4'b1001 accepted at edge 1 -> dout = 1,0,0,1 in cycles 2-5; dout_valid high for exactly 4 cycles; frame_start in cycle 2, frame_end in cycle 5; the downstream detector raises y2 one cycle after the last bit.
- Back-to-back streaming: words 4'b1101 then 4'b1001, the second offered while the first is shifting -> 8 contiguous valid bits 1,1,0,1,1,0,0,1. load_ready low while hold is full. No gap between frames.
- Hold stall: keep load_valid high with three words queued -> the third is accepted only on the edge after hold drains; the serial stream stays gapless over 12 cycles.
- LSB_FIRST=1, data_in=4'b0011 -> dout = 1,1,0,0.
- flush in the 2nd bit of a word with hold full -> next cycle dout_valid=0, busy=0, load_ready=1. A load_valid asserted together with flush is not accepted.
- Async reset pulse mid-word (reset=0 between edges) -> outputs go to reset values immediately, before the next clock edge. A new word after release serializes from bit 0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
//   master: word producer / serial consumer side (drives data_in, load_valid, flush)
//   slave : the serializer (drives load_ready and the serial outputs)
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             flush;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output data_in, load_valid, flush,
        input  load_ready, dout, dout_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  data_in, load_valid, flush,
        output load_ready, dout, dout_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register so that
// back-to-back words stream with no idle gap.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : data_in/load_valid/load_ready handshake, flush, and the serial
//           outputs dout/dout_valid/frame_start/frame_end plus busy
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_ready;
    logic               accept;
    logic               last_bit;

    // Ready only outside reset, with hold free and no flush pending.
    assign load_ready = reset && !hold_full_q && !bus.flush;
    assign accept     = bus.load_valid && load_ready;
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        if (bus.flush) begin
            state_d     = IDLE;
            shift_d     = '0;
            hold_full_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_d = bus.data_in;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // Held word has priority; load_ready is low then, so no accept can collide.
                        cnt_d = '0;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            shift_d = bus.data_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (accept) begin
                            hold_d      = bus.data_in;
                            hold_full_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus.load_ready  = load_ready;
        bus.dout        = IDLE_BIT;
        bus.dout_valid  = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.busy        = hold_full_q;
        if (state_q == SHIFT) begin
            bus.dout        = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
            bus.dout_valid  = 1'b1;
            bus.frame_start = (cnt_q == '0);
            bus.frame_end   = (cnt_q == LAST_CNT);
            bus.busy        = 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first (IDLE_BIT=0) and an LSB-first (IDLE_BIT=1)
// serializer share one stimulus and are compared against a word-queue model.
module tb_piso_serializer;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         lv;
    logic         fl;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if0 ();
    piso_serializer_if #(.WIDTH(W)) if1 ();

    assign if0.data_in    = din;
    assign if0.load_valid = lv;
    assign if0.flush      = fl;
    assign if1.data_in    = din;
    assign if1.load_valid = lv;
    assign if1.flush      = fl;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(rst), .bus(if0)
    );
    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .reset(rst), .bus(if1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queue of words still owed on the serial line; pos = bit index of the front word.
    logic [W-1:0] wq[$];
    int           pos = 0;
    bit           last_acc = 1'b0;

    function automatic int remaining();
        return wq.size() * int'(W) - pos;
    endfunction

    // Expected {dout, dout_valid, frame_start, frame_end, busy, load_ready}.
    function automatic logic [5:0] exp_vec(input bit lsb, input bit idle);
        logic b, act, rdy;
        act = (wq.size() > 0);
        b   = idle;
        if (act) b = lsb ? wq[0][pos] : wq[0][int'(W) - 1 - pos];
        rdy = rst && !fl && (remaining() <= int'(W));
        return {b, act, act && (pos == 0), act && (pos == int'(W) - 1), act, rdy};
    endfunction

    function automatic logic [5:0] obs0();
        return {if0.dout, if0.dout_valid, if0.frame_start, if0.frame_end, if0.busy, if0.load_ready};
    endfunction

    function automatic logic [5:0] obs1();
        return {if1.dout, if1.dout_valid, if1.frame_start, if1.frame_end, if1.busy, if1.load_ready};
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit rdy;
        rdy      = rst && !fl && (remaining() <= int'(W));
        last_acc = lv && rdy;
        if (!rst || fl) begin
            wq.delete();
            pos = 0;
        end else begin
            if (wq.size() > 0) begin
                pos++;
                if (pos == int'(W)) begin
                    void'(wq.pop_front());
                    pos = 0;
                end
            end
            if (last_acc) wq.push_back(din);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; lv = 1'b1; fl = 1'b0; din = 4'hF;
        wq.delete(); pos = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp += 2;
        if (obs0() !== 6'b000000) begin n_bad++; $display("FAIL reset_msb: got %b want %b", obs0(), 6'b000000); end
        if (obs1() !== 6'b100000) begin n_bad++; $display("FAIL reset_lsb: got %b want %b", obs1(), 6'b100000); end
        rst = 1'b1; lv = 1'b0;
        advance();
    endtask

    task automatic test_single();
        logic [W-1:0] seq0, seq1;
        int nval, fs_at, fe_at;
        seq0 = '0; seq1 = '0; nval = 0; fs_at = -1; fe_at = -1;
        lv = 1'b1; din = 4'b1001; fl = 1'b0;
        for (int c = -1; c < 7; c++) begin
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL single_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL single_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (if0.dout_valid) begin
                nval++;
                seq0 = {seq0[W-2:0], if0.dout};
                seq1 = {seq1[W-2:0], if1.dout};
            end
            if (if0.frame_start && fs_at < 0) fs_at = c;
            if (if0.frame_end && fe_at < 0) fe_at = c;
            advance();
            lv = 1'b0;
        end
        n_cmp += 5;
        if (seq0 !== 4'b1001) begin n_bad++; $display("FAIL single_bits: got %b want %b", seq0, 4'b1001); end
        if (seq1 !== 4'b1001) begin n_bad++; $display("FAIL single_bits_lsb: got %b want %b", seq1, 4'b1001); end
        if (nval != 4) begin n_bad++; $display("FAIL single_valid_cnt: got %0d want 4", nval); end
        if (fs_at != 0) begin n_bad++; $display("FAIL single_fstart_cycle: got %0d want 0", fs_at); end
        if (fe_at != 3) begin n_bad++; $display("FAIL single_fend_cycle: got %0d want 3", fe_at); end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] seq1;
        seq1 = '0;
        lv = 1'b1; din = 4'b0011; fl = 1'b0;
        for (int c = -1; c < 6; c++) begin
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL lsb_msbdut c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL lsb_lsbdut c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (if1.dout_valid) seq1 = {seq1[W-2:0], if1.dout};
            advance();
            lv = 1'b0;
        end
        n_cmp += 1;
        if (seq1 !== 4'b1100) begin n_bad++; $display("FAIL lsb_order: got %b want %b", seq1, 4'b1100); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq0;
        int nval;
        seq0 = '0; nval = 0;
        lv = 1'b1; din = 4'b1101; fl = 1'b0;
        for (int c = -1; c < 10; c++) begin
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL b2b_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL b2b_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (if0.dout_valid) begin nval++; seq0 = {seq0[6:0], if0.dout}; end
            advance();
            lv  = (c == -1);
            din = 4'b1001;
        end
        n_cmp += 2;
        if (seq0 !== 8'b11011001) begin n_bad++; $display("FAIL b2b_bits: got %b want %b", seq0, 8'b11011001); end
        if (nval != 8) begin n_bad++; $display("FAIL b2b_valid_cnt: got %0d want 8", nval); end
    endtask

    task automatic test_hold_stall();
        logic [W-1:0] words [3];
        int k, nval, first, lastv, c;
        k = 0; nval = 0; first = -1; lastv = -1; c = 0;
        for (int i = 0; i < 3; i++) words[i] = W'($urandom);
        fl = 1'b0;
        while ((k < 3 || wq.size() > 0) && c < 40) begin
            lv  = (k < 3);
            din = words[k < 3 ? k : 2];
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL stall_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL stall_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (if0.dout_valid) begin
                nval++;
                if (first < 0) first = c;
                lastv = c;
            end
            advance();
            if (last_acc) k++;
            c++;
        end
        lv = 1'b0;
        n_cmp += 3;
        if (k != 3) begin n_bad++; $display("FAIL stall_budget: accepted %0d want 3", k); end
        if (nval != 12) begin n_bad++; $display("FAIL stall_valid_cnt: got %0d want 12", nval); end
        if (lastv - first + 1 != 12) begin n_bad++; $display("FAIL stall_gapless: span %0d want 12", lastv - first + 1); end
    endtask

    task automatic test_flush();
        fl = 1'b0;
        for (int c = 0; c < 8; c++) begin
            lv  = (c <= 2);
            din = (c == 0) ? 4'b1010 : (c == 1) ? 4'b0110 : 4'b1111;
            fl  = (c == 2);
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL flush_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL flush_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (c == 3) begin
                n_cmp += 1;
                if ({if0.dout_valid, if0.busy, if0.load_ready} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL flush_after: got %b want %b", {if0.dout_valid, if0.busy, if0.load_ready}, 3'b001);
                end
            end
            advance();
        end
        fl = 1'b0; lv = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w2, seq0;
        w2 = W'($urandom); seq0 = '0;
        lv = 1'b1; din = 4'b1011; fl = 1'b0;
        advance();
        lv = 1'b0;
        advance();
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (obs0() !== 6'b000000) begin n_bad++; $display("FAIL areset_msb: got %b want %b", obs0(), 6'b000000); end
        if (obs1() !== 6'b100000) begin n_bad++; $display("FAIL areset_lsb: got %b want %b", obs1(), 6'b100000); end
        #1;
        rst = 1'b1;
        wq.delete(); pos = 0;
        lv = 1'b1; din = w2;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL areset_new_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL areset_new_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            if (if0.dout_valid) seq0 = {seq0[W-2:0], if0.dout};
            advance();
            lv = 1'b0;
        end
        n_cmp += 1;
        if (seq0 !== w2) begin n_bad++; $display("FAIL areset_new_word: got %b want %b", seq0, w2); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            lv  = ($urandom_range(0, 3) != 0);
            din = W'($urandom);
            fl  = ($urandom_range(0, 19) == 0);
            #1;
            n_cmp += 2;
            if (obs0() !== exp_vec(1'b0, 1'b0)) begin n_bad++; $display("FAIL rand_msb c%0d: got %b want %b", c, obs0(), exp_vec(1'b0, 1'b0)); end
            if (obs1() !== exp_vec(1'b1, 1'b1)) begin n_bad++; $display("FAIL rand_lsb c%0d: got %b want %b", c, obs1(), exp_vec(1'b1, 1'b1)); end
            advance();
        end
        lv = 1'b0; fl = 1'b0;
        repeat (12) advance();
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_hold_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
